// File: rtl/fht_pkg.sv
// ---------------------------------------------------------------------------
// fht_pkg
// Shared constants and helpers for the 1024-point FHT host loader/unloader.
//   N_POINT / N_BANK : transform length and number of RAM banks
//   A_BIT / D_BIT    : bank address width and sample width
//   IDX_BIT          : width of a linear sample index (N_POINT = 2^IDX_BIT)
//   LOAD..UNLOAD     : state encoding of the io buffer FSM
//   bit_rev10()      : 10-bit index bit reversal used for the load order
// ---------------------------------------------------------------------------
package fht_pkg;

    localparam int N_POINT = 1024;
    localparam int N_BANK  = 4;
    localparam int A_BIT   = 8;
    localparam int D_BIT   = 16;
    localparam int IDX_BIT = 10;

    localparam logic [2:0] LOAD      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] UNLOAD    = 3'd4;

    function automatic logic [IDX_BIT-1:0] bit_rev10(input logic [IDX_BIT-1:0] v);
        logic [IDX_BIT-1:0] r;
        for (int i = 0; i < IDX_BIT; i++) begin
            r[i] = v[IDX_BIT-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_io_buffer_if.sv
// ---------------------------------------------------------------------------
// fht_io_buffer_if
// Sample stream interface of fht_io_buffer.
//   Handshake rule (both directions): a transfer happens on a rising clock
//   edge where valid and ready are both high; valid must not depend on ready.
//   iDATA_IN / iVALID_IN / oREADY_IN          : input sample stream
//   oDATA_OUT / oVALID_OUT / iREADY_OUT / oLAST_OUT : result stream
// Modports:
//   slave  : the io buffer (consumes samples, produces results)
//   master : the host side (produces samples, consumes results)
// ---------------------------------------------------------------------------
interface fht_io_buffer_if #(
    parameter int D_BIT = 16
);
    logic [D_BIT-1:0] iDATA_IN;
    logic             iVALID_IN;
    logic             oREADY_IN;
    logic [D_BIT-1:0] oDATA_OUT;
    logic             oVALID_OUT;
    logic             iREADY_OUT;
    logic             oLAST_OUT;

    modport slave (
        input  iDATA_IN, iVALID_IN, iREADY_OUT,
        output oREADY_IN, oDATA_OUT, oVALID_OUT, oLAST_OUT
    );

    modport master (
        output iDATA_IN, iVALID_IN, iREADY_OUT,
        input  oREADY_IN, oDATA_OUT, oVALID_OUT, oLAST_OUT
    );
endinterface

// File: rtl/fht_skid_buf.sv
// ---------------------------------------------------------------------------
// fht_skid_buf
// Two-entry FIFO that decouples the fixed-latency bank reads from downstream
// backpressure.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : write one entry (caller guarantees a free slot)
//   o_valid, o_data, i_ready : head of queue with valid/ready pop
//   o_free         : number of empty slots (0..2)
// ---------------------------------------------------------------------------
module fht_skid_buf #(
    parameter int W = 17
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_free
);
    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign w_pop   = o_valid & i_ready;
    // A push into a full buffer is dropped rather than corrupting the head.
    assign w_push  = i_push & (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rp];
    assign o_free  = 2'd2 - r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/fht_io_buffer.sv
// ---------------------------------------------------------------------------
// fht_io_buffer
// Host-side loader/unloader for the 1024-point FHT core. Loads a sample
// stream into four 256-word banks in bit-reversed order, starts the core,
// waits for it to finish, then streams the banks back in direct order.
//   iCLK, iRESET           : clock, synchronous active-low reset
//   io (slave)             : input sample stream and result stream
//   oWR_ADDR/oWR_DATA/oWE  : bank write port (oWE one-hot per bank)
//   oRD_ADDR, iRD_DATA_0..3: common read address, per-bank read data (1 cycle)
//   oSET                   : bank set select (0 load, RES_SET unload)
//   oBANK_OWN              : high while this block owns the bank ports
//   oSTART, iRDY           : start pulse to / ready from fht_control
//   oSTATE                 : current FSM state (debug)
// A_BIT is expected to stay 8: the index arithmetic is 10-bit (1024 points).
// ---------------------------------------------------------------------------
module fht_io_buffer #(
    parameter int   A_BIT   = 8,
    parameter int   D_BIT   = 16,
    parameter logic RES_SET = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRESET,
    fht_io_buffer_if.slave   io,
    output logic [A_BIT-1:0] oWR_ADDR,
    output logic [D_BIT-1:0] oWR_DATA,
    output logic [3:0]       oWE,
    output logic [A_BIT-1:0] oRD_ADDR,
    input  logic [D_BIT-1:0] iRD_DATA_0,
    input  logic [D_BIT-1:0] iRD_DATA_1,
    input  logic [D_BIT-1:0] iRD_DATA_2,
    input  logic [D_BIT-1:0] iRD_DATA_3,
    output logic             oSET,
    output logic             oBANK_OWN,
    output logic             oSTART,
    input  logic             iRDY,
    output logic [2:0]       oSTATE
);
    import fht_pkg::*;

    logic [2:0]       r_state;
    logic [9:0]       r_k;        // load accept count
    logic [10:0]      r_j;        // unload issue count, 1024 = all issued
    logic             r_pend;     // a bank read is in flight
    logic [1:0]       r_bank_d;   // bank of the in-flight read
    logic             r_last_d;   // in-flight read is index 1023

    logic             w_in_hs;
    logic [9:0]       w_rev;
    logic             w_issue;
    logic             w_out_hs;
    logic             w_last_hs;
    logic [D_BIT-1:0] w_rd_sel;
    logic             w_skid_valid;
    logic [D_BIT:0]   w_skid_data;
    logic [1:0]       w_free;

    assign w_in_hs   = io.iVALID_IN & (r_state == LOAD);
    assign w_rev     = bit_rev10(r_k);
    assign w_out_hs  = w_skid_valid & io.iREADY_OUT;
    assign w_last_hs = w_out_hs & w_skid_data[D_BIT];

    // Issue only if the data landing next cycle will find a slot: the slots
    // free now plus one being popped now must exceed the read already in
    // flight. This keeps one read per cycle under continuous ready.
    assign w_issue = (r_state == UNLOAD) & ~r_j[10]
                   & (({1'b0, w_free} + {2'b00, w_out_hs}) > {2'b00, r_pend});

    always_comb begin
        w_rd_sel = iRD_DATA_0;
        case (r_bank_d)
            2'd0:    w_rd_sel = iRD_DATA_0;
            2'd1:    w_rd_sel = iRD_DATA_1;
            2'd2:    w_rd_sel = iRD_DATA_2;
            default: w_rd_sel = iRD_DATA_3;
        endcase
    end

    fht_skid_buf #(.W(D_BIT + 1)) u_skid (
        .i_clk   (iCLK),
        .i_rst_n (iRESET),
        .i_push  (r_pend),
        .i_data  ({r_last_d, w_rd_sel}),
        .o_valid (w_skid_valid),
        .i_ready (io.iREADY_OUT),
        .o_data  (w_skid_data),
        .o_free  (w_free)
    );

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_state  <= LOAD;
            r_k      <= '0;
            r_j      <= '0;
            r_pend   <= 1'b0;
            r_bank_d <= '0;
            r_last_d <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_bank_d <= r_j[1:0];
                r_last_d <= (r_j[9:0] == 10'd1023);
                r_j      <= r_j + 11'd1;
            end
            case (r_state)
                LOAD: begin
                    if (w_in_hs) begin
                        r_k <= r_k + 10'd1;
                        if (r_k == 10'd1023) r_state <= START;
                    end
                end
                START:     r_state <= WAIT_BUSY;
                WAIT_BUSY: if (!iRDY) r_state <= WAIT_DONE;
                WAIT_DONE: if (iRDY)  r_state <= UNLOAD;
                UNLOAD: begin
                    if (w_last_hs) begin
                        r_state <= LOAD;
                        r_k     <= '0;
                        r_j     <= '0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign io.oREADY_IN  = (r_state == LOAD);
    assign io.oDATA_OUT  = w_skid_data[D_BIT-1:0];
    assign io.oVALID_OUT = w_skid_valid;
    assign io.oLAST_OUT  = w_skid_valid & w_skid_data[D_BIT];

    assign oWE       = w_in_hs ? (4'b0001 << w_rev[1:0]) : 4'b0000;
    assign oWR_ADDR  = w_rev[9:2];
    assign oWR_DATA  = io.iDATA_IN;
    assign oRD_ADDR  = r_j[9:2];
    assign oSET      = (r_state == UNLOAD) ? RES_SET : 1'b0;
    assign oBANK_OWN = ~((r_state == START) | (r_state == WAIT_BUSY) | (r_state == WAIT_DONE));
    assign oSTART    = (r_state == START);
    assign oSTATE    = r_state;
endmodule

// File: tb/tb_fht_io_buffer.sv
module tb_fht_io_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [3:0]  we;
    logic [15:0] rd0, rd1, rd2, rd3;
    logic        set, bank_own, start, rdy;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int out_cnt  = 0;
    int start_cnt = 0;
    bit load_phase = 0;
    bit no_valid   = 1;
    logic [15:0] exp_q[$];

    fht_io_buffer_if #(.D_BIT(16)) io ();

    fht_io_buffer #(.A_BIT(8), .D_BIT(16), .RES_SET(1'b0)) u_dut (
        .iCLK(clk), .iRESET(rst_n), .io(io),
        .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oWE(we), .oRD_ADDR(rd_addr),
        .iRD_DATA_0(rd0), .iRD_DATA_1(rd1), .iRD_DATA_2(rd2), .iRD_DATA_3(rd3),
        .oSET(set), .oBANK_OWN(bank_own), .oSTART(start), .iRDY(rdy), .oSTATE(state)
    );

    // clock / bank model: word at (bank b, addr a) holds a*4+b
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd0 <= {6'd0, rd_addr, 2'd0};
        rd1 <= {6'd0, rd_addr, 2'd1};
        rd2 <= {6'd0, rd_addr, 2'd2};
        rd3 <= {6'd0, rd_addr, 2'd3};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    // one clock: sample at the falling edge, return just after the rising edge
    task automatic tick();
        logic [9:0]  r;
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        check("we_vs_valid", 32'(we != 4'd0), 32'(io.iVALID_IN & load_phase));
        if (we != 4'd0) begin
            r = rev10(wr_cnt[9:0]);
            check("wr_bank", 32'(we), 32'(4'b0001 << r[1:0]));
            check("wr_addr", 32'(wr_addr), 32'(r[9:2]));
            check("wr_data", 32'(wr_data), 32'(wr_cnt));
            wr_cnt++;
        end
        if (no_valid) check("stray_valid", 32'(io.oVALID_OUT), 32'd0);
        if (io.oVALID_OUT && io.iREADY_OUT) begin
            if (exp_q.size() == 0) begin
                check("out_extra", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(io.oDATA_OUT), 32'(e));
                check("out_last", 32'(io.oLAST_OUT), 32'(e == 16'd1023));
            end
            out_cnt++;
        end
        if (start) start_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_ready_in"}, 32'(io.oREADY_IN), 32'd1);
        check({tag, "_valid"}, 32'(io.oVALID_OUT), 32'd0);
        check({tag, "_last"}, 32'(io.oLAST_OUT), 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_own"}, 32'(bank_own), 32'd1);
        check({tag, "_set"}, 32'(set), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        io.iVALID_IN = 1'b0;
        load_phase = 0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rdy = 1'b1;
        check_reset_vals(tag);
        no_valid = 1;
        repeat (4) tick();
    endtask

    // one frame: load 1024 samples, run the core handshake, unload
    task automatic run_frame(input bit gaps, input bit rnd_rdy, input int busy_len,
                             input int rst_load, input int rst_unload);
        int k = 0;
        int g = 0;
        int guard = 0;
        bit early = 0;
        wr_cnt = 0; out_cnt = 0; start_cnt = 0;
        exp_q.delete();
        load_phase = 1; no_valid = 1;
        rdy = 1'b1; io.iREADY_OUT = 1'b1;
        check("ready_in_load", 32'(io.oREADY_IN), 32'd1);
        while (k < 1024) begin
            if (k == rst_load) begin
                do_reset("rst_load");
                return;
            end
            io.iVALID_IN = gaps ? ((g % 3) != 2) : 1'b1;
            io.iDATA_IN  = 16'(k);
            g++;
            #1;
            if (io.iVALID_IN && k == 1) begin
                check("k1_we", 32'(we), 32'h1);
                check("k1_addr", 32'(wr_addr), 32'd128);
            end
            if (io.iVALID_IN && k == 3) begin
                check("k3_we", 32'(we), 32'h1);
                check("k3_addr", 32'(wr_addr), 32'd192);
            end
            tick();
            if (io.iVALID_IN) k++;
        end
        // valid is held high outside LOAD in the gap frame; it must be ignored
        load_phase = 0;
        io.iVALID_IN = gaps;
        io.iDATA_IN  = 16'hdead;
        check("start_pulse", 32'(start), 32'd1);
        check("ready_in_start", 32'(io.oREADY_IN), 32'd0);
        check("own_start", 32'(bank_own), 32'd0);
        tick();
        rdy = 1'b0;
        check("start_one_cycle", 32'(start), 32'd0);
        check("own_wait", 32'(bank_own), 32'd0);
        repeat (busy_len) tick();
        check("own_wait_done", 32'(bank_own), 32'd0);
        check("ready_in_wait", 32'(io.oREADY_IN), 32'd0);
        rdy = 1'b1;
        for (int i = 0; i < 1024; i++) exp_q.push_back(16'(i));
        tick();
        check("start_count", 32'(start_cnt), 32'd1);
        check("own_unload", 32'(bank_own), 32'd1);
        check("set_unload", 32'(set), 32'd0);
        check("valid_lat0", 32'(io.oVALID_OUT), 32'd0);
        no_valid = 0;
        io.iREADY_OUT = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        check("valid_lat1", 32'(io.oVALID_OUT), 32'd0);
        io.iREADY_OUT = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        check("valid_lat2", 32'(io.oVALID_OUT), 32'd1);
        while (out_cnt < 1024 && guard < 20000) begin
            if (rst_unload >= 0 && out_cnt >= rst_unload) begin
                do_reset("rst_unload");
                return;
            end
            if (io.oREADY_IN) early = 1;
            io.iREADY_OUT = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
        end
        check("out_count", 32'(out_cnt), 32'd1024);
        check("out_queue_empty", 32'(exp_q.size()), 32'd0);
        check("ready_in_early", 32'(early), 32'd0);
        check("ready_in_next", 32'(io.oREADY_IN), 32'd1);
        check("wr_count", 32'(wr_cnt), 32'd1024);
        check("set_load", 32'(set), 32'd0);
        check("valid_after", 32'(io.oVALID_OUT), 32'd0);
        no_valid = 1;
    endtask

    initial begin
        io.iVALID_IN = 1'b0;
        io.iDATA_IN = '0;
        io.iREADY_OUT = 1'b1;
        rdy = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_vals("reset");
        tick();

        run_frame(1'b0, 1'b0, 5200, -1, -1);  // ramp, continuous handshakes
        run_frame(1'b1, 1'b1, 20, -1, -1);    // input gaps, random output ready
        run_frame(1'b0, 1'b0, 10, 500, -1);   // reset during load
        run_frame(1'b0, 1'b0, 10, -1, -1);    // restart from index 0
        run_frame(1'b0, 1'b0, 10, -1, 300);   // reset during unload
        run_frame(1'b0, 1'b0, 10, -1, -1);    // restart after unload reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fht_io_buffer.md
Name: fht_io_buffer

Overview:
- Host-side loader/unloader for the 1024-point FHT core.
- Accepts a sample stream and writes it into the four 256-word RAM banks in bit-reversed order, then pulses start to fht_control.
- Waits for the transform to finish, then reads the four banks back in direct order and streams the results out with valid/ready.
- Owns the bank ports only outside the transform; an external mux uses oBANK_OWN to select between this block and the FHT core.

Parameters:
- A_BIT, 8, bank address width; N = 4 * 2^A_BIT = 1024 points.
- D_BIT, 16, sample width.
- RES_SET, 0, bank set (source_data value) that holds the final result; drives oSET during UNLOAD.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset, synchronous, active-low.
- iDATA_IN  in  D_BIT  input sample.
- iVALID_IN  in  1  input sample valid.
- oREADY_IN  out  1  block accepts input (LOAD state only).
- oDATA_OUT  out  D_BIT  result sample.
- oVALID_OUT  out  1  result valid.
- iREADY_OUT  in  1  downstream accepts the result.
- oLAST_OUT  out  1  marks result index 1023.
- oWR_ADDR  out  A_BIT  bank write address.
- oWR_DATA  out  D_BIT  bank write data.
- oWE  out  4  one-hot bank write enable.
- oRD_ADDR  out  A_BIT  read address, common to all four banks.
- iRD_DATA_0..3  in  D_BIT each  bank read data; read latency is 1 cycle.
- oSET  out  1  bank set select: 0 while loading, RES_SET while unloading.
- oBANK_OWN  out  1  high when this block drives the bank ports.
- oSTART  out  1  start pulse to fht_control.
- iRDY  in  1  fht_control ready.

Behaviour:
- Reset applies on the iCLK edge with iRESET=0.
  - State = LOAD; all counters = 0.
  - oSTART=0, oWE=0, oVALID_OUT=0, oLAST_OUT=0, oBANK_OWN=1, oSET=0.
  - Skid buffer is emptied.
  - Reset mid-operation discards all partial load/unload data. The next load starts at index 0.
- Address mapping on load:
  - k = 10-bit accept count; r = bit-reverse(k).
  - Bank = r[1:0]; addr = r[9:2].
  - Each accepted sample is written in the same cycle: combinational oWE one-hot, oWR_ADDR, oWR_DATA = iDATA_IN.
- Address mapping on unload: j = 10-bit issue count; bank = j[1:0]; addr = j[9:2].
- State LOAD:
  - oREADY_IN=1; a handshake is iVALID_IN & oREADY_IN, and k increments on each handshake.
  - On the handshake with k=1023, go to START.
- State START (1 cycle):
  - oSTART=1, oBANK_OWN=0, oREADY_IN=0; then go to WAIT_BUSY.
- State WAIT_BUSY: stay until iRDY=0, then go to WAIT_DONE.
- State WAIT_DONE:
  - Stay until iRDY=1.
  - On that cycle set oBANK_OWN=1 and go to UNLOAD.
  - oBANK_OWN stays 0 through both WAIT states.
- State UNLOAD:
  - A read is issued when (j<1024) & the skid buffer has a free slot, counting in-flight reads. j increments per issue.
  - The bank index is delayed 1 cycle to select iRD_DATA_x into the skid buffer.
  - Output handshake is oVALID_OUT & iREADY_OUT.
  - oLAST_OUT=1 with the element whose j=1023.
  - After the last handshake, go to LOAD with k=j=0 and oSET=0.
- Throughput: 1 sample/cycle in both directions under continuous valid/ready.
  - First oVALID_OUT comes 2 cycles after entering UNLOAD: 1 RAM latency cycle + 1 register.
- Backpressure: iREADY_OUT=0 must never lose or duplicate a sample. The skid buffer depth is 2 and it is never overrun.
- iVALID_IN is ignored outside LOAD.
- iRDY=1 during WAIT_BUSY only holds the state; there is no timeout.

Decomposition:
- Shared package fht_pkg holds:
  - N_POINT=1024, N_BANK=4, A_BIT, D_BIT.
  - State encoding {LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD}.
  - Bit-reverse function for the 10-bit index.
- One sub-module: fht_skid_buf.
  - 2-entry, D_BIT+1 wide (data + last).
  - Synchronous active-low reset.
  - Ports: push / data in, valid/ready out, and a free-slot count output.

Test Plan:
- Load ramp 0..1023 with continuous valid:
  - Sample k=1 writes bank 0, addr 128 (r=512).
  - k=3 writes bank 0, addr 192 (r=768).
  - oSTART pulses exactly once, 1 cycle after k=1023 is accepted.
- Bank model with bank=j[1:0], addr=j[9:2], data=j; iRDY toggles low 1 cycle after oSTART and high 5200 cycles later:
  - Output is 0..1023 in order with oLAST_OUT only on 1023.
  - First valid arrives 2 cycles after iRDY rises.
- Random iREADY_OUT (50%) during unload → all 1024 values delivered in order, no duplicates, and the skid buffer never overflows.
- Gaps on iVALID_IN (every 3rd cycle low) → 1024 writes, the correct bit-reversed addresses, and no extra oWE.
- iRESET=0 asserted at load index 500, and separately mid-unload at j=300:
  - Outputs return to their reset values.
  - The next load restarts at index 0 with no stray oVALID_OUT.
- Back-to-back frames with a continuous output ready → the second frame's oREADY_IN rises 1 cycle after the first frame's last output handshake.
